quad_decoder: RTL
=================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, position counter width in bits.
REQ-002 SHALL have parameter FILT_LEN, default 4, number of consecutive stable cycles the glitch filter requires (range 2..15).
REQ-003 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset; it is the only reset.
REQ-005 SHALL have port qa_in, input, 1 bit, quadrature channel A, asynchronous to clk.
REQ-006 SHALL have port qb_in, input, 1 bit, quadrature channel B, asynchronous to clk.
REQ-007 SHALL have port hold, input, 1 bit, freezes count when high.
REQ-008 SHALL have port clr, input, 1 bit, synchronous count clear.
REQ-009 SHALL have port step, output, 1 bit, one-cycle pulse per valid quadrature transition.
REQ-010 SHALL have port dir, output, 1 bit, direction of the last valid transition (1=up, 0=down).
REQ-011 SHALL have port count, output, CNT_W bits, signed two's-complement position.
REQ-012 SHALL have port err, output, 1 bit, sticky flag for an illegal double-bit transition.

Function
REQ-013 SHALL pass qa_in and qb_in each through a 2-flop synchronizer before any other use.
REQ-014 SHALL track the last accepted AB state in a 4-state Gray FSM: S00, S01, S11, S10.
REQ-015 SHALL treat S00->S01->S11->S10->S00 as up and the reverse sequence as down.
REQ-016 SHALL, on an up transition, pulse step for one cycle, set dir=1 and increment count by 1.
REQ-017 SHALL, on a down transition, pulse step for one cycle, set dir=0 and decrement count by 1.
REQ-018 SHALL wrap count modulo 2^CNT_W in both directions, with no saturation and no flag.
REQ-019 SHALL, when both bits change in one accepted sample, set err, produce no step, leave count and dir unchanged, and move the FSM to the new state.
REQ-020 SHALL, when hold=1, still pulse step and update dir but leave count unchanged.
REQ-021 SHALL, when clr=1, load count=0 on the next edge; clr overrides hold and any same-cycle step; FSM state, dir and err are unaffected.
REQ-022 SHALL clear err only by reset.
REQ-023 SHALL register step, dir, count and err, with no combinational path from input to output.
REQ-024 SHALL, without the filter, raise step exactly 3 clk cycles after the qa_in/qb_in edge (2 synchronizer cycles + 1 register cycle).

Reset
REQ-025 SHALL, while rst=1, force count=0, step=0, dir=0, err=0 and clear the filter counters.
REQ-026 SHALL, on the first accepted sample after rst deasserts, load the FSM from that sample with no step and no err.
REQ-027 SHALL, on rst asserted mid-transition, discard the pending transition.

Configuration
REQ-028 SHALL, with QDEC_FILTER_EN defined, accept a new synchronized AB value only after it has been stable for FILT_LEN consecutive cycles; latency then equals 3+FILT_LEN cycles.
REQ-029 SHALL, without QDEC_FILTER_EN, accept every synchronized sample directly and instantiate no filter logic.

Structure
REQ-030 SHALL place FSM state encodings (S00..S10) and the direction constants in shared package qdec_pkg.
REQ-031 SHALL implement the 2-flop synchronizer plus optional stable-count filter as sub-module qdec_sync_filter, one instance per channel.

Verification
REQ-032 SHALL cover: reset, then 8 up steps (AB 00,01,11,10 x2) -> 8 step pulses, dir=1, count=8.
REQ-033 SHALL cover: from count=0, 1 down step -> count=all-ones (-1), dir=0, a single step pulse.
REQ-034 SHALL cover: AB 00->11 in one sample -> err=1, no step, count unchanged; err stays 1 until rst.
REQ-035 SHALL cover: hold=1 during 4 up steps -> 4 step pulses, count unchanged; clr with a same-cycle step -> count=0.
REQ-036 SHALL cover, with QDEC_FILTER_EN and FILT_LEN=4: a 2-cycle glitch on qa_in -> no step; a stable edge -> step at cycle 7.
REQ-037 SHALL cover: rst asserted for 1 cycle mid-sequence -> all outputs 0; the first post-reset sample produces no step.

Source files
------------

// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder.
//
// Contents:
//   qdec_state_t : last accepted AB state (S00, S01, S11, S10). The encoding
//                  equals the AB bit pattern, so a sample casts directly.
//   qdec_move_t  : classification of one accepted sample against the state.
//   DIR_UP/DOWN  : values driven on the dir output.
//   FILT_CNT_W   : width of the stable-count filter counter (FILT_LEN <= 15).
//   gray_pos()   : position (0..3) of a state along the up sequence.
//   classify()   : turns (previous, current) into none/up/down/illegal.
package qdec_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } qdec_state_t;

    typedef enum logic [1:0] {
        MOVE_NONE = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        MOVE_ERR  = 2'd3
    } qdec_move_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int FILT_CNT_W = 4;

    // Gray-to-binary: 00->0, 01->1, 11->2, 10->3.
    function automatic logic [1:0] gray_pos(input qdec_state_t s);
        logic [1:0] v;
        v = s;
        return {v[1], v[1] ^ v[0]};
    endfunction

    // The positional difference modulo 4 tells the move: +1 up, -1 down,
    // 2 means both bits flipped in one sample.
    function automatic qdec_move_t classify(input qdec_state_t prev,
                                            input qdec_state_t cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        case (d)
            2'd0:    return MOVE_NONE;
            2'd1:    return MOVE_UP;
            2'd3:    return MOVE_DOWN;
            default: return MOVE_ERR;
        endcase
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// Per-channel input conditioning: 2-flop synchronizer, optionally followed
// by a stable-count glitch filter.
//
// Build option: define QDEC_FILTER_EN to include the filter. Without it the
// synchronizer output is passed straight through and no filter logic exists.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (clears the filter counter)
//   din  : raw asynchronous input
//   dout : conditioned level
//
// The synchronizer flops are deliberately not reset so that they keep
// tracking the pin during reset; the first sample after reset is then the
// real input level rather than a forced zero.
module qdec_sync_filter
    import qdec_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        sync_reg <= {sync_reg[0], din};
    end

`ifdef QDEC_FILTER_EN
    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic [FILT_CNT_W-1:0] cnt_reg;
    logic                  out_reg;

    // The counter runs while the synchronized level differs from the
    // accepted level; any return to the accepted level restarts it. Since
    // the input is one bit, "differs for N cycles" means "stable for N".
    // During reset the accepted level follows the synchronizer so that no
    // stale level is accepted afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            out_reg <= sync_reg[1];
        end else if (sync_reg[1] == out_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            out_reg <= sync_reg[1];
        end else begin
            cnt_reg <= cnt_reg + FILT_CNT_W'(1);
        end
    end

    assign dout = out_reg;
`else
    logic unused_cfg;
    assign unused_cfg = rst & (FILT_LEN > 0);
    assign dout       = sync_reg[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: conditions the A/B inputs, tracks the Gray state and
// maintains a signed wrapping position count.
//
// Build option: QDEC_FILTER_EN adds a FILT_LEN-cycle stable filter per
// channel (latency 3+FILT_LEN instead of 3 cycles from pin edge to step).
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   qa_in  : channel A (asynchronous)
//   qb_in  : channel B (asynchronous)
//   hold   : freeze count (step and dir still update)
//   clr    : load count=0 on next edge; beats hold and a same-cycle step
//   step   : one-cycle pulse per valid transition
//   dir    : direction of last valid transition (1=up)
//   count  : CNT_W-bit two's-complement position, wraps
//   err    : sticky illegal double-bit transition flag (cleared by rst only)
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qa_in,
    input  logic             qb_in,
    input  logic             hold,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic [1:0] raw_ab;
    logic [1:0] acc_ab;

    assign raw_ab = {qa_in, qb_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        qdec_sync_filter #(
            .FILT_LEN(FILT_LEN)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .din (raw_ab[gi]),
            .dout(acc_ab[gi])
        );
    end

    qdec_state_t      state_reg, state_next;
    logic             first_reg, first_next;
    logic             step_reg, step_next;
    logic             dir_reg, dir_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_reg, err_next;

    qdec_state_t sample_state;
    qdec_move_t  move;

    assign sample_state = qdec_state_t'(acc_ab);
    assign move         = classify(state_reg, sample_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S00;
            first_reg <= 1'b1;
            step_reg  <= 1'b0;
            dir_reg   <= 1'b0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            first_reg <= first_next;
            step_reg  <= step_next;
            dir_reg   <= dir_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        first_next = 1'b0;
        step_next  = 1'b0;
        dir_next   = dir_reg;
        count_next = count_reg;
        err_next   = err_reg;

        if (first_reg) begin
            // The first sample after reset only seeds the state; whatever
            // was in flight before reset is not a transition.
            state_next = sample_state;
        end else begin
            case (move)
                MOVE_UP: begin
                    state_next = sample_state;
                    step_next  = 1'b1;
                    dir_next   = DIR_UP;
                    if (!hold) count_next = count_reg + CNT_W'(1);
                end
                MOVE_DOWN: begin
                    state_next = sample_state;
                    step_next  = 1'b1;
                    dir_next   = DIR_DOWN;
                    if (!hold) count_next = count_reg - CNT_W'(1);
                end
                MOVE_ERR: begin
                    // Direction is unknowable; resync to the new state.
                    state_next = sample_state;
                    err_next   = 1'b1;
                end
                default: ;
            endcase
        end

        if (clr) count_next = '0;
    end

    assign step  = step_reg;
    assign dir   = dir_reg;
    assign count = count_reg;
    assign err   = err_reg;

endmodule
